// File: rtl/shift_sequencer.sv
// Multi-cycle logarithmic shifter: one 2**k stage per clock for SLL/SRL/SRA, start/done handshake.
// Optional rotate-left for op 11 when SHIFT_SEQ_ROTATE_EN is defined; otherwise op 11 flags err.
module shift_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in,
    input  logic [AMT_W-1:0] amt,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned    K_W    = (AMT_W > 1) ? $clog2(AMT_W) : 1;
    localparam logic [K_W-1:0] K_TOP  = K_W'(AMT_W - 1);
    localparam logic [AMT_W:0] W_FULL = (AMT_W + 1)'(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_work;
    logic [AMT_W-1:0]   r_amt;
    logic [1:0]         r_op;
    logic [K_W-1:0]     r_k;
    logic [WIDTH-1:0]   r_out;
    logic               r_err;

    logic [AMT_W-1:0]   w_dist;
    logic [WIDTH-1:0]   w_stage;
    logic               w_illegal;
    logic               w_last;

    assign w_dist = AMT_W'(1) << r_k;
    assign w_last = (r_k == '0);

`ifdef SHIFT_SEQ_ROTATE_EN
    assign w_illegal = 1'b0;
`else
    assign w_illegal = (r_op == 2'b11);
`endif

    // One stage of the log shifter; the stage is skipped when the matching amount bit is clear.
    always_comb begin
        w_stage = r_work;
        if (r_amt[r_k]) begin
            case (r_op)
                OP_SLL:  w_stage = r_work << w_dist;
                OP_SRL:  w_stage = r_work >> w_dist;
                OP_SRA:  w_stage = $signed(r_work) >>> w_dist;
`ifdef SHIFT_SEQ_ROTATE_EN
                default: w_stage = (r_work << w_dist) | (r_work >> (W_FULL - {1'b0, w_dist}));
`else
                default: w_stage = r_work;
`endif
            endcase
        end
    end

    always_comb begin
        w_state_next = IDLE;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready        = 1'b1;
                w_state_next = start ? SHIFT : IDLE;
            end
            SHIFT: begin
                busy         = 1'b1;
                w_state_next = w_last ? DONE : SHIFT;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // err is captured with out so both hold until the next request completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_work <= '0;
            r_amt  <= '0;
            r_op   <= '0;
            r_k    <= K_TOP;
            r_out  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_work <= in;
                        r_amt  <= amt;
                        r_op   <= op;
                        r_k    <= K_TOP;
                    end
                end
                SHIFT: begin
                    r_work <= w_stage;
                    if (w_last) begin
                        r_out <= w_stage;
                        r_err <= w_illegal;
                        r_k   <= K_TOP;
                    end else begin
                        r_k   <= r_k - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;
    assign err = r_err;

endmodule
